cga_vram_fetch: RTL and testbench

Video-memory fetch sequencer for the CGA datapath: owns the 5-bit dot-clock sequence counter, issues character/attribute (or graphics byte-pair) reads to the single-port VRAM, and produces the `vram_read_char`, `vram_read_att`, `charrom_read` and `disp_pipeline` strobes that the pixel/attribute pipeline consumes. It interleaves ISA CPU accesses into fixed free slots of each character cell. It sits between the CRTC (address and row source), the VRAM SRAM port, and the pixel pipeline.

---
 rtl/cga_vram_fetch.sv | 144 ++++++++++++++
 tb/tb_cga_vram_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_fetch.sv
// CGA video-memory fetch sequencer: dot-clock sequence counter, VRAM
// character/attribute fetch, pipeline strobes and interleaved CPU slots.
module cga_vram_fetch #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hres_mode,
    input  logic                  grph_mode,
    input  logic [12:0]           crtc_addr,
    input  logic [4:0]            row_addr,
    input  logic                  display_enable,
    output logic [4:0]            clk_seq,
    output logic                  crtc_clk,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic                  vram_rd,
    output logic                  vram_we,
    output logic [7:0]            vram_wdata,
    input  logic [7:0]            vram_data,
    output logic                  vram_read_char,
    output logic                  vram_read_att,
    output logic                  charrom_read,
    output logic                  disp_pipeline,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_rdata
);

    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUE,
        C_ACK
    } cpu_st_t;

    cpu_st_t r_cst;
    cpu_st_t w_cst_nxt;

    logic       r_hres;
    logic       r_vid;
    logic       r_cpu_we;
    logic       r_ack_rd;
    logic [7:0] r_rdata;

    logic [4:0]            w_seq_nxt;
    logic                  w_hres_nxt;
    logic                  w_vid_nxt;
    logic [4:0]            w_p;
    logic [4:0]            w_last;
    logic                  w_vid_slot;
    logic                  w_cpu_slot;
    logic                  w_grant;
    logic [13:0]           w_vid14;
    logic [ADDR_WIDTH-1:0] w_vid_addr;
    logic                  w_unused;

    assign w_unused = ^row_addr[4:1];

    // Everything below describes the cycle about to start, so outputs register cleanly.
    always_comb begin
        w_seq_nxt  = clk_seq + 5'd1;
        w_hres_nxt = (w_seq_nxt == 5'd0) ? hres_mode : r_hres;
        w_p        = w_hres_nxt ? {1'b0, w_seq_nxt[3:0]} : w_seq_nxt;
        w_vid_nxt  = (w_p == 5'd0) ? display_enable : r_vid;
        w_last     = w_hres_nxt ? 5'd15 : 5'd31;
        w_vid_slot = w_vid_nxt && (w_p == 5'd0 || w_p == 5'd2);
        w_cpu_slot = (w_p == 5'd8) || (w_p == 5'd12)
                   || (!w_hres_nxt && (w_p == 5'd24 || w_p == 5'd28))
                   || (!w_vid_nxt && (w_p == 5'd0 || w_p == 5'd2));
        if (grph_mode)
            w_vid14 = {row_addr[0], crtc_addr[11:0], w_p[1]};
        else
            w_vid14 = {crtc_addr, w_p[1]};
        w_vid_addr = ADDR_WIDTH'(w_vid14);
    end

    always_comb begin
        w_cst_nxt = r_cst;
        w_grant   = 1'b0;
        unique case (r_cst)
            C_IDLE: begin
                if (w_cpu_slot && cpu_req) begin
                    w_grant   = 1'b1;
                    w_cst_nxt = C_ISSUE;
                end
            end
            C_ISSUE: w_cst_nxt = C_ACK;
            C_ACK:   w_cst_nxt = C_IDLE;
            default: w_cst_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_seq        <= '0;
            r_hres         <= 1'b0;
            r_vid          <= 1'b0;
            r_cst          <= C_IDLE;
            r_cpu_we       <= 1'b0;
            r_ack_rd       <= 1'b0;
            r_rdata        <= '0;
            crtc_clk       <= 1'b0;
            disp_pipeline  <= 1'b0;
            vram_read_char <= 1'b0;
            vram_read_att  <= 1'b0;
            charrom_read   <= 1'b0;
            vram_rd        <= 1'b0;
            vram_we        <= 1'b0;
            vram_addr      <= '0;
            vram_wdata     <= '0;
            cpu_ack        <= 1'b0;
        end else begin
            clk_seq        <= w_seq_nxt;
            r_hres         <= w_hres_nxt;
            r_vid          <= w_vid_nxt;
            r_cst          <= w_cst_nxt;
            crtc_clk       <= (w_p == w_last);
            disp_pipeline  <= (w_p == w_last);
            vram_read_char <= (w_p == 5'd1);
            vram_read_att  <= (w_p == 5'd3);
            charrom_read   <= (w_p == 5'd4);
            vram_rd        <= w_vid_slot || (w_grant && !cpu_we);
            vram_we        <= w_grant && cpu_we;
            if (w_vid_slot) begin
                vram_addr <= w_vid_addr;
            end else if (w_grant) begin
                vram_addr <= cpu_addr;
                r_cpu_we  <= cpu_we;
                if (cpu_we)
                    vram_wdata <= cpu_wdata;
            end
            cpu_ack  <= (r_cst == C_ISSUE);
            r_ack_rd <= (r_cst == C_ISSUE) && !r_cpu_we;
            if (r_ack_rd)
                r_rdata <= vram_data;
        end
    end

    // SRAM data arrives in the ack cycle; bypass it so rdata is valid with the ack.
    assign cpu_rdata = r_ack_rd ? vram_data : r_rdata;

endmodule

// File: tb/tb_cga_vram_fetch.sv
// Self-checking bench for cga_vram_fetch: cell-level reference model,
// directed literal cases and randomized CPU/CRTC traffic.
module tb_cga_vram_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        hres_mode = 1'b0;
    logic        grph_mode = 1'b0;
    logic [12:0] crtc_addr = '0;
    logic [4:0]  row_addr = '0;
    logic        display_enable = 1'b0;
    logic [4:0]  clk_seq;
    logic        crtc_clk;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_data = '0;
    logic        vram_read_char;
    logic        vram_read_att;
    logic        charrom_read;
    logic        disp_pipeline;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    cga_vram_fetch #(.ADDR_WIDTH(14)) dut (
        .clk(clk), .reset_n(reset_n),
        .hres_mode(hres_mode), .grph_mode(grph_mode),
        .crtc_addr(crtc_addr), .row_addr(row_addr),
        .display_enable(display_enable),
        .clk_seq(clk_seq), .crtc_clk(crtc_clk),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_data(vram_data),
        .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
        .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    // SRAM: synchronous read, contents start as addr[7:0].
    logic [7:0] mem [16384];
    logic [7:0] sm  [16384];
    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i] = i[7:0];
            sm[i]  = i[7:0];
        end
    end
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        if (vram_rd) vram_data <= mem[vram_addr];
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_prt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Reference model: cell timing from the sequence/slot rules.
    int         m_seq = 0;
    bit         m_hres = 0, m_vid = 0;
    bit         m_iss = 0, m_iss_we = 0;
    logic [13:0] m_iss_addr = '0;
    logic [7:0]  m_iss_wd = '0;
    bit         e_rd = 0, e_we = 0, e_ack = 0;
    bit         e_char = 0, e_att = 0, e_rom = 0, e_end = 0;
    logic [13:0] e_addr = '0;
    logic [7:0]  e_wdata = '0, e_rdata = '0;

    always @(posedge clk or negedge reset_n) begin : model
        int p, last;
        bit blk, slot;
        if (!reset_n) begin
            m_seq = 0; m_hres = 0; m_vid = 0;
            m_iss = 0; m_iss_we = 0; m_iss_addr = '0; m_iss_wd = '0;
            e_rd = 0; e_we = 0; e_ack = 0;
            e_char = 0; e_att = 0; e_rom = 0; e_end = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else begin
            m_seq = (m_seq + 1) % 32;
            if (m_seq == 0) m_hres = hres_mode;
            p = m_hres ? m_seq % 16 : m_seq;
            last = m_hres ? 15 : 31;
            if (p == 0) m_vid = display_enable;
            e_char = (p == 1);
            e_att  = (p == 3);
            e_rom  = (p == 4);
            e_end  = (p == last);
            slot = (p inside {8, 12}) || (!m_hres && (p inside {24, 28}))
                 || (!m_vid && (p inside {0, 2}));
            blk = m_iss || e_ack;
            e_ack = m_iss;
            if (m_iss) begin
                if (m_iss_we) sm[m_iss_addr] = m_iss_wd;
                else e_rdata = sm[m_iss_addr];
            end
            m_iss = 0; e_rd = 0; e_we = 0;
            if (m_vid && (p inside {0, 2})) begin
                e_rd = 1;
                if (grph_mode) e_addr = {row_addr[0], crtc_addr[11:0], p == 2};
                else e_addr = {crtc_addr, p == 2};
            end else if (slot && cpu_req && !blk) begin
                m_iss = 1; m_iss_we = cpu_we;
                m_iss_addr = cpu_addr; m_iss_wd = cpu_wdata;
                e_addr = cpu_addr;
                if (cpu_we) begin e_we = 1; e_wdata = cpu_wdata; end
                else e_rd = 1;
            end
        end
    end

    wire [46:0] dut_v = {clk_seq, crtc_clk, disp_pipeline, vram_read_char,
                         vram_read_att, charrom_read, vram_rd, vram_we,
                         vram_addr, vram_wdata, cpu_ack, cpu_rdata};
    wire [46:0] exp_v = {5'(m_seq), e_end, e_end, e_char, e_att, e_rom,
                         e_rd, e_we, e_addr, e_wdata, e_ack, e_rdata};

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if (dut_v === exp_v) n_pass++;
            else begin
                if (n_prt < 20)
                    $display("FAIL model t=%0t: got %h want %h", $time, dut_v, exp_v);
                n_prt++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_seq(input int s);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (clk_seq == 5'(s)) return;
        end
        chk("wait_seq_timeout", 0, 1);
    endtask

    logic [31:0] g_rd, g_char, g_att, g_rom, g_crtc;
    logic [13:0] g_addr [32];
    logic [7:0]  g_data [32];

    // Call at a clk_seq==0 cycle; records n cycles starting there.
    task automatic grab(input int n);
        g_rd = '0; g_char = '0; g_att = '0; g_rom = '0; g_crtc = '0;
        for (int k = 0; k < n; k++) begin
            g_rd[k]   = vram_rd;
            g_char[k] = vram_read_char;
            g_att[k]  = vram_read_att;
            g_rom[k]  = charrom_read;
            g_crtc[k] = crtc_clk;
            g_addr[k] = vram_addr;
            g_data[k] = vram_data;
            if (k < n - 1) tick();
        end
    endtask

    bit rand_done = 0;

    initial begin
        int we_s, ack_s, rd_s, ch_s, pulses, p1, p2;
        logic [13:0] rd_a;
        logic [7:0]  rdat;
        bit seen;
        #1 reset_n = 1'b0;
        #1 chk_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {17'd0, dut_v}, 64'd0);
        #1 reset_n = 1'b1;

        // 80-col text fetch
        hres_mode = 1; grph_mode = 0; display_enable = 1;
        crtc_addr = 13'h0123; row_addr = 0;
        wait_seq(0);
        grab(16);
        chk("hres_rd_map", g_rd[15:0], 16'h0005);
        chk("hres_char_addr", g_addr[0], 14'h0246);
        chk("hres_attr_addr", g_addr[2], 14'h0247);
        chk("hres_char_data", g_data[1], 8'h46);
        chk("hres_strobes", {g_char[15:0], g_att[15:0], g_rom[15:0]},
            {16'h0002, 16'h0008, 16'h0010});
        chk("hres_crtc_clk", g_crtc[15:0], 16'h8000);

        // low-res graphics fetch
        hres_mode = 0; grph_mode = 1; row_addr = 5'd1; crtc_addr = 13'h0010;
        wait_seq(0);
        grab(32);
        chk("lres_rd_map", g_rd, 32'h5);
        chk("lres_addr0", g_addr[0], 14'h2020);
        chk("lres_addr2", g_addr[2], 14'h2021);
        chk("lres_crtc_clk", g_crtc, 32'h8000_0000);

        // CPU write raised at p9, hi-res
        hres_mode = 1; grph_mode = 0; display_enable = 1;
        wait_seq(0);
        wait_seq(9);
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1FFF; cpu_wdata = 8'h5A;
        we_s = -1; ack_s = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (vram_we && we_s < 0) we_s = clk_seq;
            if (cpu_ack) begin ack_s = clk_seq; break; end
        end
        cpu_req = 0;
        chk("wr_we_seq", we_s, 12);
        chk("wr_ack_seq", ack_s, 13);

        // CPU read in display-off cell, raised at p31
        hres_mode = 0; display_enable = 0;
        wait_seq(0);
        wait_seq(31);
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0ABC;
        rd_s = -1; ack_s = -1; rd_a = '0; rdat = '0; ch_s = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (vram_rd && rd_s < 0) begin rd_s = clk_seq; rd_a = vram_addr; end
            if (cpu_ack) begin
                ack_s = clk_seq; rdat = cpu_rdata; ch_s = vram_read_char;
                break;
            end
        end
        cpu_req = 0;
        chk("rd_seq", rd_s, 0);
        chk("rd_addr", rd_a, 14'h0ABC);
        chk("rd_ack_seq", ack_s, 1);
        chk("rd_data", rdat, 8'hBC);
        chk("rd_char_strobe", ch_s, 1);
        tick();
        chk("rd_data_held", cpu_rdata, 8'hBC);

        // hres toggled mid-cell
        display_enable = 1;
        wait_seq(5);
        hres_mode = 1;
        pulses = 0; p1 = -1; p2 = -1;
        for (int i = 0; i < 64 && pulses < 2; i++) begin
            tick();
            if (crtc_clk) begin
                if (pulses == 0) p1 = clk_seq; else p2 = clk_seq;
                pulses++;
            end
        end
        chk("tog_first_end", p1, 31);
        chk("tog_second_end", p2, 15);

        // reset mid-cell with a CPU read in flight
        wait_seq(10);
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0100;
        wait_seq(13);
        reset_n = 0; cpu_req = 0;
        #1;
        chk("rst_mid_outs", {17'd0, dut_v}, 64'd0);
        tick();
        reset_n = 1;
        #1 chk("rel_seq0", clk_seq, 0);
        tick();
        chk("rel_seq1", clk_seq, 1);
        tick();
        chk("rel_seq2", clk_seq, 2);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            seen |= cpu_ack;
            tick();
        end
        chk("rel_no_ack", seen, 0);

        // randomized traffic
        fork
            begin : env
                while (!rand_done) begin
                    tick();
                    if ($urandom_range(0, 39) == 0) hres_mode = $urandom_range(0, 1);
                    if ($urandom_range(0, 19) == 0) grph_mode = $urandom_range(0, 1);
                    if ($urandom_range(0, 15) == 0) display_enable = $urandom_range(0, 1);
                    if ($urandom_range(0, 7) == 0) crtc_addr = 13'($urandom);
                    if ($urandom_range(0, 7) == 0) row_addr = 5'($urandom);
                end
            end
            begin : master
                for (int t = 0; t < 150; t++) begin
                    bit got;
                    cpu_req = 1; cpu_we = $urandom_range(0, 1);
                    cpu_addr = 14'($urandom); cpu_wdata = 8'($urandom);
                    got = 0;
                    for (int i = 0; i < 40; i++) begin
                        tick();
                        if (cpu_ack) begin got = 1; break; end
                    end
                    if (!got) chk("rand_ack_timeout", 0, 1);
                    if ($urandom_range(0, 3) != 0) begin
                        cpu_req = 0;
                        repeat ($urandom_range(0, 20)) tick();
                    end
                end
                cpu_req = 0;
                rand_done = 1;
            end
        join
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
